bus_master: RTL

Single-outstanding bus initiator that turns CPU load/store requests into transfers on the HSEL/HADDR/HWRITE/HBE/HWDATA/HREADY/HRDATA peripheral bus. It drives the same single-slave select protocol that the memory-mapped config peripherals, such as the UART clock control register, respond to. The block sits between the core's load/store unit and a peripheral. It handles byte-lane steering, sign/zero extension of read data, misalignment detection and, optionally, a ready timeout.

---
 rtl/bus_master.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/bus_master.sv
`default_nettype none
// ============================================================================
// Module   : bus_master
// Brief    : Single-outstanding CPU load/store to HSEL/HREADY bus initiator;
//            optional ready timeout enabled by BUS_MASTER_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
module bus_master #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clock,
    input  logic        nRst,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic        HSEL,
    output logic [31:0] HADDR,
    output logic        HWRITE,
    output logic [3:0]  HBE,
    output logic [31:0] HWDATA,
    input  logic        HREADY,
    input  logic [31:0] HRDATA
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_RELEASE = 2'd2,
        S_ERR     = 2'd3
    } state_t;

    state_t      r_state, w_state_next;
    logic        r_busy, r_done, r_err, r_hsel, r_hwrite, r_unsigned;
    logic        w_done_next, w_err_next, w_hsel_next, w_hwrite_next, w_unsigned_next;
    logic [31:0] r_rdata, r_haddr, r_hwdata;
    logic [31:0] w_rdata_next, w_haddr_next, w_hwdata_next;
    logic [3:0]  r_hbe, w_hbe_next;
    logic [1:0]  r_size, r_lane, w_size_next, w_lane_next;

    logic        w_illegal;
    logic [3:0]  w_req_hbe;
    logic [31:0] w_req_hwdata;
    logic [15:0] w_lane_data;
    logic [31:0] w_load;

`ifdef BUS_MASTER_TIMEOUT_EN
    localparam int             CW        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0]  c_timeout = CW'(TIMEOUT_CYCLES);
    logic [CW-1:0] r_cnt, w_cnt_next;
`else
    localparam int c_timeout_unused = TIMEOUT_CYCLES;
`endif

    assign busy   = r_busy;
    assign done   = r_done;
    assign err    = r_err;
    assign rdata  = r_rdata;
    assign HSEL   = r_hsel;
    assign HADDR  = r_haddr;
    assign HWRITE = r_hwrite;
    assign HBE    = r_hbe;
    assign HWDATA = r_hwdata;

    always_comb begin
        w_illegal = (size == 2'd3) ||
                    (size == 2'd1 && addr[0]) ||
                    (size == 2'd2 && addr[1:0] != 2'b00);
        case (size)
            2'd0:    begin w_req_hbe = 4'b0001 << addr[1:0];          w_req_hwdata = {4{wdata[7:0]}};  end
            2'd1:    begin w_req_hbe = addr[1] ? 4'b1100 : 4'b0011;   w_req_hwdata = {2{wdata[15:0]}}; end
            2'd2:    begin w_req_hbe = 4'b1111;                       w_req_hwdata = wdata;            end
            default: begin w_req_hbe = 4'b0000;                       w_req_hwdata = wdata;            end
        endcase
    end

    // Byte offset times eight shifts the addressed lane down; half lanes are always even-aligned.
    always_comb begin
        w_lane_data = 16'(HRDATA >> {r_lane, 3'b000});
        case (r_size)
            2'd0:    w_load = {{24{~r_unsigned & w_lane_data[7]}}, w_lane_data[7:0]};
            2'd1:    w_load = {{16{~r_unsigned & w_lane_data[15]}}, w_lane_data};
            default: w_load = HRDATA;
        endcase
    end

    always_comb begin
        w_state_next    = r_state;
        w_done_next     = 1'b0;
        w_err_next      = 1'b0;
        w_rdata_next    = r_rdata;
        w_hsel_next     = r_hsel;
        w_haddr_next    = r_haddr;
        w_hwrite_next   = r_hwrite;
        w_hbe_next      = r_hbe;
        w_hwdata_next   = r_hwdata;
        w_size_next     = r_size;
        w_lane_next     = r_lane;
        w_unsigned_next = r_unsigned;
`ifdef BUS_MASTER_TIMEOUT_EN
        w_cnt_next      = r_cnt;
`endif
        case (r_state)
            S_IDLE: begin
                if (req) begin
                    if (w_illegal) begin
                        w_state_next = S_ERR;
                    end else begin
                        w_state_next    = S_REQ;
                        w_hsel_next     = 1'b1;
                        w_haddr_next    = {addr[31:2], 2'b00};
                        w_hwrite_next   = we;
                        w_hbe_next      = w_req_hbe;
                        w_hwdata_next   = w_req_hwdata;
                        w_size_next     = size;
                        w_lane_next     = addr[1:0];
                        w_unsigned_next = is_unsigned;
`ifdef BUS_MASTER_TIMEOUT_EN
                        w_cnt_next      = '0;
`endif
                    end
                end
            end
            S_REQ: begin
                if (HREADY) begin
                    w_state_next = S_RELEASE;
                    w_hsel_next  = 1'b0;
                    w_hbe_next   = 4'b0000;
                    w_done_next  = 1'b1;
                    if (!r_hwrite) begin
                        w_rdata_next = w_load;
                    end
                end else begin
`ifdef BUS_MASTER_TIMEOUT_EN
                    w_cnt_next = r_cnt + CW'(1);
                    if (w_cnt_next == c_timeout) begin
                        w_state_next = S_RELEASE;
                        w_hsel_next  = 1'b0;
                        w_hbe_next   = 4'b0000;
                        w_done_next  = 1'b1;
                        w_err_next   = 1'b1;
                        w_rdata_next = '0;
                    end
`endif
                end
            end
            // Wait out the slave's ready from the finished access before reopening.
            S_RELEASE: begin
                if (!HREADY) begin
                    w_state_next = S_IDLE;
                end
            end
            S_ERR: begin
                w_state_next = S_IDLE;
                w_done_next  = 1'b1;
                w_err_next   = 1'b1;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge nRst) begin
        if (!nRst) begin
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_rdata    <= '0;
            r_hsel     <= 1'b0;
            r_haddr    <= '0;
            r_hwrite   <= 1'b0;
            r_hbe      <= '0;
            r_hwdata   <= '0;
            r_size     <= '0;
            r_lane     <= '0;
            r_unsigned <= 1'b0;
`ifdef BUS_MASTER_TIMEOUT_EN
            r_cnt      <= '0;
`endif
        end else begin
            r_state    <= w_state_next;
            r_busy     <= (w_state_next != S_IDLE);
            r_done     <= w_done_next;
            r_err      <= w_err_next;
            r_rdata    <= w_rdata_next;
            r_hsel     <= w_hsel_next;
            r_haddr    <= w_haddr_next;
            r_hwrite   <= w_hwrite_next;
            r_hbe      <= w_hbe_next;
            r_hwdata   <= w_hwdata_next;
            r_size     <= w_size_next;
            r_lane     <= w_lane_next;
            r_unsigned <= w_unsigned_next;
`ifdef BUS_MASTER_TIMEOUT_EN
            r_cnt      <= w_cnt_next;
`endif
        end
    end

endmodule
`default_nettype wire
